// File: rtl/pap_wb_pkg.sv
// ---------------------------------------------------------------------------
// pap_wb_pkg
//   Shared types and constants for the register-file write-back front end.
//   XLEN        : data width of results and register file words
//   REG_IDX_W   : width of a register index (x0..x31)
//   REG_COUNT   : number of architectural GP registers
//   wb_entry_t  : one buffered long-latency result {idx, data}
// ---------------------------------------------------------------------------
package pap_wb_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int REG_COUNT = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   Small FIFO of wb_entry_t holding long-latency results while the ALU owns
//   the register file write port.
//   clk, rst_n     : clock / asynchronous active-low reset (empties the FIFO)
//   clr            : synchronous clear (pipeline flush), wins over push/pop
//   push, push_entry : write an entry (ignored when full)
//   pop            : discard the head entry (ignored when empty)
//   head           : current head entry (valid when !empty)
//   full, empty    : occupancy flags, both derived from count only
//   count          : number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module wb_fifo
  import pap_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap naturally on overflow;
  // the separate count is what tells full from empty when pointers are equal.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after it was pushed.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//   Write-side front end of the GP register file. Merges single-cycle ALU
//   results with long-latency (load / mul-div) results, drives the single
//   register file write port, and keeps a pending-write scoreboard for decode.
//   clk, rst_n        : clock / asynchronous active-low reset
//   flush             : drop buffered results, clear scoreboard, kill writes
//   alu_valid/idx/data: ALU result, always accepted, wins the write port
//   lsu_valid/idx/data, lsu_ready : long-latency result, valid/ready handshake
//   issue_valid/idx   : long-latency op issued, marks its destination busy
//   busy_mask         : bit i set while register i has a write outstanding
//   wb_en/idx/data    : registered register file write port (x0 never written)
//   XLEN must equal pap_wb_pkg::XLEN, FIFO_DEPTH a power of two >= 2.
// ---------------------------------------------------------------------------
module regfile_writeback #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alu_valid,
  input  logic [4:0]      alu_idx,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_idx,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_idx,
  output logic [31:0]     busy_mask,
  output logic            wb_en,
  output logic [4:0]      wb_idx,
  output logic [XLEN-1:0] wb_data
);

  import pap_wb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // ---------------- long-latency buffer ----------------
  wb_entry_t        push_entry;
  wb_entry_t        fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push;
  logic             fifo_pop;

  assign push_entry = '{idx: lsu_idx, data: lsu_data};

  // Ready depends only on occupancy so the source never sees a
  // combinational loop through lsu_valid. A full FIFO refuses even when it
  // pops that cycle.
  assign lsu_ready = ~fifo_full;
  assign fifo_push = lsu_valid & lsu_ready & ~flush;
  // The FIFO head only competes when the ALU is quiet. Because the pop
  // looks at the registered head, a freshly accepted result cannot bypass.
  assign fifo_pop  = ~flush & ~alu_valid & ~fifo_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (flush),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // ---------------- arbiter and output register ----------------
  logic            sel_valid;
  logic [4:0]      sel_idx;
  logic [XLEN-1:0] sel_data;

  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_idx_q, wb_idx_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_data  = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_idx   = alu_idx;
      sel_data  = alu_data;
    end else if (fifo_pop) begin
      sel_valid = 1'b1;
      sel_idx   = fifo_head.idx;
      sel_data  = fifo_head.data;
    end
  end

  // A result aimed at x0 still uses up its slot, but leaves the port
  // deasserted and the last idx/data on the bus untouched.
  always_comb begin
    wb_en_d   = 1'b0;
    wb_idx_d  = wb_idx_q;
    wb_data_d = wb_data_q;
    if (!flush && sel_valid && (sel_idx != '0)) begin
      wb_en_d   = 1'b1;
      wb_idx_d  = sel_idx;
      wb_data_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_q   <= 1'b0;
      wb_idx_q  <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_idx_q  <= wb_idx_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_idx  = wb_idx_q;
  assign wb_data = wb_data_q;

  // ---------------- pending-write scoreboard ----------------
  logic [REG_COUNT-1:0] busy_q, busy_d;

  assign busy_d[0] = 1'b0;

  // Per register: flush clears, an issue sets, a pop of that register
  // clears. Set beats clear so a re-issue racing the old result stays busy.
  for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_busy
    logic set_bit;
    logic clr_bit;
    assign set_bit    = issue_valid && (issue_idx == REG_IDX_W'(gi));
    assign clr_bit    = fifo_pop && (fifo_head.idx == REG_IDX_W'(gi));
    assign busy_d[gi] = flush   ? 1'b0 :
                        set_bit ? 1'b1 :
                        clr_bit ? 1'b0 : busy_q[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_mask = busy_q;

  // ---------------- protocol checks ----------------
  // Decode must not issue to a register still in flight, unless that
  // register's result is retiring in the very same cycle.
  a_issue_not_busy : assert property (@(posedge clk) disable iff (!rst_n)
    (issue_valid && !flush && (issue_idx != '0) &&
     !(fifo_pop && (fifo_head.idx == issue_idx))) |-> !busy_q[issue_idx])
    else $error("issue to busy register x%0d", issue_idx);

  a_no_x0_write : assert property (@(posedge clk) disable iff (!rst_n)
    wb_en_q |-> (wb_idx_q != '0))
    else $error("write-back to x0");

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CNT_W'(FIFO_DEPTH))
    else $error("fifo count overflow");

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            alu_valid;
  logic [4:0]      alu_idx;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_idx;
  logic [XLEN-1:0] lsu_data;
  logic            issue_valid;
  logic [4:0]      issue_idx;
  logic [31:0]     busy_mask;
  logic            wb_en;
  logic [4:0]      wb_idx;
  logic [XLEN-1:0] wb_data;

  always #5 clk = ~clk;

  regfile_writeback #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .alu_valid   (alu_valid),
    .alu_idx     (alu_idx),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_idx     (lsu_idx),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .busy_mask   (busy_mask),
    .wb_en       (wb_en),
    .wb_idx      (wb_idx),
    .wb_data     (wb_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    flush = 1'b0; alu_valid = 1'b0; alu_idx = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_idx = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_idx = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic en, input logic [4:0] idx,
                            input logic [31:0] data, input logic [31:0] busy, input logic rdy);
    check({tag, ".wb_en"},     64'(wb_en),     64'(en));
    check({tag, ".wb_idx"},    64'(wb_idx),    64'(idx));
    check({tag, ".wb_data"},   64'(wb_data),   64'(data));
    check({tag, ".busy_mask"}, 64'(busy_mask), 64'(busy));
    check({tag, ".lsu_ready"}, 64'(lsu_ready), 64'(rdy));
  endtask

  // One record per cycle: inputs driven, then outputs expected after the edge.
  typedef struct {
    logic        av; logic [4:0] ai; logic [31:0] ad;
    logic        lv; logic [4:0] li; logic [31:0] ld;
    logic        iv; logic [4:0] ii;
    logic        en; logic [4:0] idx; logic [31:0] data; logic [31:0] busy; logic rdy;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  // Reference model state for the random phase.
  typedef struct { logic [4:0] idx; logic [31:0] data; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_busy;
  logic        m_en;
  logic [4:0]  m_idx;
  logic [31:0] m_data;

  task automatic model_edge();
    logic       rdy;
    logic       src_v;
    logic [4:0] s_idx;
    logic [31:0] s_data;
    ent_t       e;
    rdy = (m_q.size() < DEPTH);
    if (flush) begin
      m_q.delete();
      m_busy = '0;
      m_en   = 1'b0;
    end else begin
      src_v = 1'b0; s_idx = '0; s_data = '0;
      if (alu_valid) begin
        src_v = 1'b1; s_idx = alu_idx; s_data = alu_data;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        src_v = 1'b1; s_idx = e.idx; s_data = e.data;
        m_busy[e.idx] = 1'b0;
      end
      if (src_v && s_idx != 5'd0) begin
        m_en = 1'b1; m_idx = s_idx; m_data = s_data;
      end else begin
        m_en = 1'b0;
      end
      if (issue_valid && issue_idx != 5'd0) m_busy[issue_idx] = 1'b1;
      if (lsu_valid && rdy) m_q.push_back('{idx: lsu_idx, data: lsu_data});
    end
  endtask

  initial begin
    //              av   ai     ad              lv   li      ld            iv   ii     en   idx     data            busy          rdy
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0,  1'b1};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0,  1'b1};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 5'd7, 1'b0, 5'd5,  32'hDEADBEEF, 32'h80, 1'b1};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd5,  32'hDEADBEEF, 32'h80, 1'b1};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd5,  32'hDEADBEEF, 32'h80, 1'b1};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  32'h1234, 1'b0, 5'd0, 1'b0, 5'd5,  32'hDEADBEEF, 32'h80, 1'b1};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b1, 5'd7,  32'h1234,     32'h0,  1'b1};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd7,  32'h1234,     32'h0,  1'b1};
    vecs[8]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0,  32'hAAAA, 1'b0, 5'd0, 1'b0, 5'd7,  32'h1234,     32'h0,  1'b1};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 5'd0, 1'b0, 5'd7,  32'h1234,     32'h0,  1'b1};
    vecs[10] = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd10, 32'hA0,   1'b0, 5'd0, 1'b1, 5'd1,  32'h11,       32'h0,  1'b1};
    vecs[11] = '{1'b1, 5'd2, 32'h22,       1'b1, 5'd11, 32'hB0,   1'b0, 5'd0, 1'b1, 5'd2,  32'h22,       32'h0,  1'b0};
    vecs[12] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd12, 32'hC0,   1'b0, 5'd0, 1'b1, 5'd3,  32'h33,       32'h0,  1'b0};
    vecs[13] = '{1'b1, 5'd4, 32'h44,       1'b1, 5'd12, 32'hC0,   1'b0, 5'd0, 1'b1, 5'd4,  32'h44,       32'h0,  1'b0};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 32'hC0,   1'b0, 5'd0, 1'b1, 5'd10, 32'hA0,       32'h0,  1'b1};
    vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 32'hC0,   1'b0, 5'd0, 1'b1, 5'd11, 32'hB0,       32'h0,  1'b1};
    vecs[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b1, 5'd12, 32'hC0,       32'h0,  1'b1};
    vecs[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd12, 32'hC0,       32'h0,  1'b1};

    // ---- reset ----
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // ---- directed table: ALU latency, scoreboard, x0, backpressure/drain ----
    for (int i = 0; i < NVEC; i++) begin
      alu_valid = vecs[i].av; alu_idx = vecs[i].ai; alu_data = vecs[i].ad;
      lsu_valid = vecs[i].lv; lsu_idx = vecs[i].li; lsu_data = vecs[i].ld;
      issue_valid = vecs[i].iv; issue_idx = vecs[i].ii;
      step();
      $display("vec %0d: wb_en=%0b wb_idx=%0d wb_data=0x%08h busy=0x%08h ready=%0b",
               i, wb_en, wb_idx, wb_data, busy_mask, lsu_ready);
      check_outs($sformatf("vec%0d", i), vecs[i].en, vecs[i].idx, vecs[i].data,
                 vecs[i].busy, vecs[i].rdy);
    end
    idle();

    // ---- flush with two buffered entries and busy bits set ----
    issue_valid = 1'b1; issue_idx = 5'd3; step();
    issue_idx = 5'd4; step();
    idle();
    alu_valid = 1'b1; alu_idx = 5'd1; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_idx = 5'd3; lsu_data = 32'h300; step();
    alu_idx = 5'd2; alu_data = 32'h2;
    lsu_idx = 5'd4; lsu_data = 32'h400; step();
    check("flush_pre.ready", 64'(lsu_ready), 64'(1'b0));
    check("flush_pre.busy",  64'(busy_mask), 64'(32'h18));
    flush = 1'b1;
    alu_idx = 5'd5; alu_data = 32'h55;
    lsu_idx = 5'd6; lsu_data = 32'h66;
    issue_valid = 1'b1; issue_idx = 5'd9;
    step();
    $display("flush: wb_en=%0b wb_idx=%0d busy=0x%08h ready=%0b", wb_en, wb_idx, busy_mask, lsu_ready);
    check_outs("flush", 1'b0, 5'd2, 32'h2, 32'h0, 1'b1);
    idle();
    step();
    check_outs("flush_post", 1'b0, 5'd2, 32'h2, 32'h0, 1'b1);

    // ---- async reset mid-drain ----
    alu_valid = 1'b1; alu_idx = 5'd1; alu_data = 32'h10;
    lsu_valid = 1'b1; lsu_idx = 5'd20; lsu_data = 32'h2000; step();
    alu_idx = 5'd2; alu_data = 32'h20;
    lsu_idx = 5'd21; lsu_data = 32'h2100; step();
    idle();
    step();
    check("drain.wb_idx",  64'(wb_idx),  64'(5'd20));
    check("drain.wb_data", 64'(wb_data), 64'(32'h2000));
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: wb_en=%0b wb_idx=%0d wb_data=0x%08h", wb_en, wb_idx, wb_data);
    check_outs("async_rst", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_outs("post_rst", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);

    // ---- randomized phase against the reference model ----
    m_q.delete(); m_busy = '0; m_en = 1'b0; m_idx = '0; m_data = '0;
    begin
      logic hold;
      logic [4:0] cand;
      hold = 1'b0;
      for (int c = 0; c < 400; c++) begin
        flush     = ($urandom_range(0, 31) == 0);
        alu_valid = ($urandom_range(0, 9) < 4);
        alu_idx   = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
        if (!hold) begin
          lsu_valid = ($urandom_range(0, 1) == 1);
          lsu_idx   = 5'($urandom_range(0, 31));
          lsu_data  = $urandom;
        end
        cand        = 5'($urandom_range(0, 31));
        issue_idx   = cand;
        issue_valid = ($urandom_range(0, 2) == 0) && !m_busy[cand];
        #1;
        check($sformatf("rnd%0d.lsu_ready", c), 64'(lsu_ready), 64'(m_q.size() < DEPTH));
        hold = lsu_valid && !(lsu_ready && !flush);
        model_edge();
        step();
        $display("rnd %0d: wb_en=%0b wb_idx=%0d wb_data=0x%08h busy=0x%08h", c, wb_en, wb_idx, wb_data, busy_mask);
        check($sformatf("rnd%0d.wb_en", c),     64'(wb_en),     64'(m_en));
        check($sformatf("rnd%0d.wb_idx", c),    64'(wb_idx),    64'(m_idx));
        check($sformatf("rnd%0d.wb_data", c),   64'(wb_data),   64'(m_data));
        check($sformatf("rnd%0d.busy_mask", c), 64'(busy_mask), 64'(m_busy));
      end
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
